// File: rtl/booth_driver_4bit_if.sv
// Bundle between the Booth driver and its environment: operand handshake,
// memristor cell control and the product handshake. The slave modport is the driver.
interface booth_driver_4bit_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [3:0] multiplier;
  logic signed [3:0] multiplicand;
  logic              abort;
  logic              cell_rst;
  logic              cell_start;
  logic              cell_top;
  logic              cell_bottom;
  logic signed [3:0] cell_delta_m;
  logic signed [7:0] cell_result;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] product;
  logic              range_err;
  logic              busy;

  modport slave (
    input  in_valid, multiplier, multiplicand, abort, cell_result, out_ready,
    output in_ready, cell_rst, cell_start, cell_top, cell_bottom, cell_delta_m,
           out_valid, product, range_err, busy
  );

  modport master (
    output in_valid, multiplier, multiplicand, abort, cell_result, out_ready,
    input  in_ready, cell_rst, cell_start, cell_top, cell_bottom, cell_delta_m,
           out_valid, product, range_err, busy
  );
endinterface

// File: rtl/booth_driver_4bit.sv
// Sequencer for a 4-step radix-2 Booth memristor cell: clears the cell, feeds it
// one Booth bit pair per cycle, then captures the cell accumulator as the product.
module booth_driver_4bit (
  input  logic                clk,
  input  logic                rst,
  booth_driver_4bit_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, CLR, RUN, CAP, DONE, ABT} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        step_reg, step_next;
  logic signed [3:0] q_reg, q_next;
  logic signed [3:0] m_reg, m_next;
  logic signed [7:0] product_reg, product_next;
  logic              range_err_reg, range_err_next;
  // Set by reset and cleared on the first edge after it: holds the cell in
  // clear for one cycle before the first operand can be taken.
  logic              init_reg;
  logic [3:0][1:0]   pair_tbl;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pair
      if (gi == 0) begin : g_first
        assign pair_tbl[gi] = {q_reg[0], 1'b0};
      end else begin : g_rest
        assign pair_tbl[gi] = {q_reg[gi], q_reg[gi-1]};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      step_reg      <= 2'd0;
      q_reg         <= '0;
      m_reg         <= '0;
      product_reg   <= '0;
      range_err_reg <= 1'b0;
      init_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      q_reg         <= q_next;
      m_reg         <= m_next;
      product_reg   <= product_next;
      range_err_reg <= range_err_next;
      init_reg      <= 1'b0;
    end
  end

  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    q_next         = q_reg;
    m_next         = m_reg;
    product_next   = product_reg;
    range_err_next = range_err_reg;
    case (state_reg)
      IDLE: begin
        if (!init_reg && bus.in_valid) begin
          q_next     = bus.multiplier;
          m_next     = bus.multiplicand;
          state_next = CLR;
        end
      end
      CLR: begin
        step_next  = 2'd0;
        state_next = bus.abort ? ABT : RUN;
      end
      RUN: begin
        // The counter wraps 3 -> 0 on the way out, leaving it at zero for the next run.
        step_next = step_reg + 2'd1;
        if (bus.abort) begin
          step_next  = 2'd0;
          state_next = ABT;
        end else if (step_reg == 2'd3) begin
          state_next = CAP;
        end
      end
      CAP: begin
        if (bus.abort) begin
          state_next = ABT;
        end else begin
          product_next   = bus.cell_result;
          range_err_next = (m_reg == 4'sb1000);
          state_next     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      ABT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Cell controls decode only registered state, so they settle once after each edge.
  always_comb begin
    bus.in_ready     = (state_reg == IDLE) && !init_reg;
    bus.busy         = (state_reg != IDLE);
    bus.cell_rst     = init_reg || (state_reg == CLR) || (state_reg == ABT);
    bus.cell_start   = (state_reg == RUN);
    bus.cell_top     = 1'b0;
    bus.cell_bottom  = 1'b0;
    if (state_reg == RUN) begin
      {bus.cell_top, bus.cell_bottom} = pair_tbl[step_reg];
    end
    bus.cell_delta_m = (state_reg != IDLE) ? m_reg : 4'sd0;
    bus.out_valid    = (state_reg == DONE);
    bus.product      = product_reg;
    bus.range_err    = range_err_reg;
  end
endmodule

// File: tb/tb_booth_driver_4bit.sv
// Bench for booth_driver_4bit: behavioural Booth cell, table vectors, hand-written
// abort/reset sequences and random operands checked against plain multiplication.
module tb_booth_driver_4bit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  booth_driver_4bit_if bus();
  booth_driver_4bit dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural cell: adds or subtracts M scaled by the step number since its last clear.
  logic signed [7:0] cell_acc = '0;
  logic [1:0]        cell_k = 2'd0;
  logic signed [7:0] m_ext;
  assign m_ext = bus.cell_delta_m;
  assign bus.cell_result = cell_acc;
  always @(posedge clk) begin
    if (bus.cell_rst) begin
      cell_acc <= '0;
      cell_k   <= 2'd0;
    end else if (bus.cell_start) begin
      if ({bus.cell_top, bus.cell_bottom} == 2'b01) cell_acc <= cell_acc + (m_ext <<< cell_k);
      if ({bus.cell_top, bus.cell_bottom} == 2'b10) cell_acc <= cell_acc - (m_ext <<< cell_k);
      cell_k <= cell_k + 2'd1;
    end
  end

  typedef struct {
    logic signed [3:0] m;
    logic signed [3:0] q;
    logic [7:0]        pairs;  // step i pair at [2*i+:2]
    logic [7:0]        prod;
    logic              rerr;
    int                stall;
    logic              hold;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] booth_pairs(input logic [3:0] q);
    logic [4:0] qx;
    logic [7:0] r;
    qx = {q, 1'b0};
    for (int i = 0; i < 4; i++) r[2*i +: 2] = qx[i+1 -: 2];
    return r;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " in_ready"}, {7'd0, bus.in_ready}, 8'd1);
  endtask

  // Offers an operand pair at a negedge; returns at the negedge after acceptance (CLR).
  task automatic start_op(input logic signed [3:0] m, input logic signed [3:0] q,
                          input logic hold, input string name);
    wait_ready(name);
    bus.multiplier   = q;
    bus.multiplicand = m;
    bus.in_valid     = 1'b1;
    @(negedge clk);
    bus.in_valid     = hold;
    bus.multiplier   = 4'($urandom);
    bus.multiplicand = 4'($urandom);
  endtask

  task automatic do_op(input vec_t v, input string name);
    start_op(v.m, v.q, v.hold, name);
    chk({name, " clr cell_rst"}, {7'd0, bus.cell_rst}, 8'd1);
    chk({name, " clr cell_start"}, {7'd0, bus.cell_start}, 8'd0);
    chk({name, " clr busy"}, {7'd0, bus.busy}, 8'd1);
    chk({name, " clr delta_m"}, 8'(bus.cell_delta_m), 8'(v.m));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({name, " run cell_start"}, {7'd0, bus.cell_start}, 8'd1);
      chk({name, " run cell_rst"}, {7'd0, bus.cell_rst}, 8'd0);
      chk({name, " run pair"}, {6'd0, bus.cell_top, bus.cell_bottom}, {6'd0, v.pairs[2*i +: 2]});
      chk({name, " run delta_m"}, 8'(bus.cell_delta_m), 8'(v.m));
      chk({name, " run in_ready"}, {7'd0, bus.in_ready}, 8'd0);
    end
    @(negedge clk);
    chk({name, " cap cell_start"}, {7'd0, bus.cell_start}, 8'd0);
    chk({name, " cap pair"}, {6'd0, bus.cell_top, bus.cell_bottom}, 8'd0);
    chk({name, " cap out_valid"}, {7'd0, bus.out_valid}, 8'd0);
    @(negedge clk);
    chk({name, " done out_valid"}, {7'd0, bus.out_valid}, 8'd1);
    chk({name, " product"}, bus.product, v.prod);
    chk({name, " range_err"}, {7'd0, bus.range_err}, {7'd0, v.rerr});
    if (v.stall > 0) bus.abort = 1'b1;
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk({name, " stall out_valid"}, {7'd0, bus.out_valid}, 8'd1);
      chk({name, " stall product"}, bus.product, v.prod);
      chk({name, " stall in_ready"}, {7'd0, bus.in_ready}, 8'd0);
      chk({name, " stall busy"}, {7'd0, bus.busy}, 8'd1);
    end
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, " exit out_valid"}, {7'd0, bus.out_valid}, 8'd0);
    chk({name, " exit busy"}, {7'd0, bus.busy}, 8'd0);
    chk({name, " exit in_ready"}, {7'd0, bus.in_ready}, 8'd1);
    $display("[TB] op %s M=%0d Q=%0d product=%0d range_err=%0b", name, v.m, v.q,
             $signed(bus.product), bus.range_err);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, " out_valid"}, {7'd0, bus.out_valid}, 8'd0);
    chk({name, " cell_rst"}, {7'd0, bus.cell_rst}, 8'd1);
    chk({name, " in_ready"}, {7'd0, bus.in_ready}, 8'd0);
    chk({name, " busy"}, {7'd0, bus.busy}, 8'd0);
    chk({name, " cell_start"}, {7'd0, bus.cell_start}, 8'd0);
    chk({name, " product"}, bus.product, 8'd0);
    chk({name, " range_err"}, {7'd0, bus.range_err}, 8'd0);
  endtask

  vec_t vecs[6];
  vec_t rv;

  initial begin
    vecs[0] = '{m: 4'sd3,  q: -4'sd2, pairs: 8'b11_11_10_00, prod: 8'hFA, rerr: 1'b0, stall: 0, hold: 1'b0};
    vecs[1] = '{m: -4'sd7, q: -4'sd7, pairs: 8'b10_00_01_10, prod: 8'h31, rerr: 1'b0, stall: 0, hold: 1'b0};
    vecs[2] = '{m: 4'sd7,  q: 4'sd7,  pairs: 8'b01_11_11_10, prod: 8'h31, rerr: 1'b0, stall: 5, hold: 1'b0};
    vecs[3] = '{m: -4'sd8, q: 4'sd1,  pairs: 8'b00_00_01_10, prod: 8'hF8, rerr: 1'b1, stall: 1, hold: 1'b1};
    vecs[4] = '{m: 4'sd2,  q: 4'sd3,  pairs: 8'b00_01_11_10, prod: 8'h06, rerr: 1'b0, stall: 0, hold: 1'b0};
    vecs[5] = '{m: 4'sd5,  q: -4'sd3, pairs: 8'b11_10_01_10, prod: 8'hF1, rerr: 1'b0, stall: 2, hold: 1'b0};

    bus.in_valid = 1'b0; bus.multiplier = '0; bus.multiplicand = '0;
    bus.abort = 1'b0; bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_state("por");
    rst = 1'b1;
    #1;
    chk("por release cell_rst", {7'd0, bus.cell_rst}, 8'd1);
    chk("por release in_ready", {7'd0, bus.in_ready}, 8'd0);
    @(negedge clk);
    chk("por ready", {7'd0, bus.in_ready}, 8'd1);
    chk("por cell_rst off", {7'd0, bus.cell_rst}, 8'd0);

    for (int i = 0; i < 4; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Abort while idle has no effect.
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("idle abort in_ready", {7'd0, bus.in_ready}, 8'd1);
    chk("idle abort busy", {7'd0, bus.busy}, 8'd0);

    // Abort sampled while RUN is on step 1.
    start_op(4'sd6, 4'sd5, 1'b0, "abort");
    repeat (2) @(negedge clk);
    chk("abort pre cell_start", {7'd0, bus.cell_start}, 8'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort cleanup cell_rst", {7'd0, bus.cell_rst}, 8'd1);
    chk("abort cleanup cell_start", {7'd0, bus.cell_start}, 8'd0);
    chk("abort cleanup out_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("abort cleanup in_ready", {7'd0, bus.in_ready}, 8'd0);
    @(negedge clk);
    chk("abort idle in_ready", {7'd0, bus.in_ready}, 8'd1);
    chk("abort idle cell_rst", {7'd0, bus.cell_rst}, 8'd0);
    chk("abort idle out_valid", {7'd0, bus.out_valid}, 8'd0);
    do_op(vecs[4], "post_abort");

    // Reset asserted mid-run at step 2.
    start_op(4'sd6, -4'sd5, 1'b0, "midrst");
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    chk_reset_state("midrst held");
    rst = 1'b1;
    #1;
    chk("midrst release cell_rst", {7'd0, bus.cell_rst}, 8'd1);
    chk("midrst release in_ready", {7'd0, bus.in_ready}, 8'd0);
    @(negedge clk);
    do_op(vecs[5], "post_rst");

    for (int n = 0; n < 30; n++) begin
      int mi, qi;
      rv.m = 4'($urandom);
      rv.q = 4'($urandom);
      mi = rv.m;
      qi = rv.q;
      rv.pairs = booth_pairs(rv.q);
      rv.prod  = 8'(mi * qi);
      rv.rerr  = (mi == -8);
      rv.stall = int'($urandom_range(0, 3));
      rv.hold  = 1'($urandom);
      do_op(rv, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
